// File: rtl/rv32_fetch_unit.sv
// RV32 instruction fetch stage: PC, instruction-bus request and fetch-to-decode register.
// Define RV32_FETCH_SKID_EN to park a stalled bus response in a one-entry skid buffer.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] instr_address_out,
    output logic        instr_read_out,
    input  logic [31:0] instr_data_in,
    input  logic        instr_ready_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_ALIGN  = 32'hFFFF_FFFC;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_inc;
    logic        fetching;
    logic        accept;

`ifdef RV32_FETCH_SKID_EN
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        drain;
`endif

    // Request/acceptance qualifiers; HOLD means the skid holds a parked instruction.
    always_comb begin
        pc_inc = pc_q + 32'd4;
`ifdef RV32_FETCH_SKID_EN
        fetching = (state_q == FETCH);
        drain    = (state_q == HOLD) && !stall_in;
`else
        fetching = 1'b1;
`endif
        accept = fetching && instr_ready_in && !stall_in;
    end

    assign instr_read_out    = fetching;
    assign instr_address_out = pc_q;

    always_comb begin
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
`ifdef RV32_FETCH_SKID_EN
        state_d      = state_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
`endif
        if (branch_taken_in) begin
            // Redirect beats stall and any bus response; returning to FETCH empties the skid.
            pc_d    = branch_pc_in & PC_ALIGN;
            valid_d = 1'b0;
`ifdef RV32_FETCH_SKID_EN
            state_d = FETCH;
`endif
        end else if (!stall_in) begin
            if (accept) begin
                pc_out_d = pc_q;
                instr_d  = instr_data_in;
                valid_d  = 1'b1;
                pc_d     = pc_inc;
`ifdef RV32_FETCH_SKID_EN
            end else if (drain) begin
                pc_out_d = skid_pc_q;
                instr_d  = skid_instr_q;
                valid_d  = 1'b1;
                state_d  = FETCH;
`endif
            end else if (flush_in) begin
                valid_d = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
`ifdef RV32_FETCH_SKID_EN
        else if (fetching && instr_ready_in) begin
            // Bus completed while decode is stalled: park it and move on to the next address.
            skid_pc_d    = pc_q;
            skid_instr_d = instr_data_in;
            pc_d         = pc_inc;
            state_d      = HOLD;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_VECTOR & PC_ALIGN;
            pc_out_q <= 32'h0000_0000;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

`ifdef RV32_FETCH_SKID_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            skid_pc_q    <= 32'h0000_0000;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end
`endif

    assign pc_out    = pc_out_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

endmodule
